fadd_arbiter: RTL and testbench
===============================

# fadd_arbiter

Round-robin arbiter and two-stage issue/response pipeline that shares a single combinational `fadd` single-precision adder instance among `N_REQ` requesters. Each requester presents an operand pair over a valid/ready handshake. The block:
- grants one requester per cycle;
- registers the operands into the adder's input stage;
- captures the sum with the winner's ID into a response register;
- returns it on one shared response channel with backpressure.

It sits between the FPU-using units (e.g. multiple issue slots or a vector lane group) and the adder.

## Interface
- `N_REQ`, default 4: number of requesters; legal range 2..16.
- `IDW`, default `$clog2(N_REQ)`: width of requester ID.

Ports:
- `clk`  in  1  sole clock; all state updates on rising edge.
- `rstn`  in  1  asynchronous, active-low reset.
- `req_valid`  in  `N_REQ`  per-requester request valid.
- `req_ready`  out  `N_REQ`  per-requester accept; at most one bit high per cycle.
- `req_x1`  in  `32*N_REQ`  operand 1, IEEE-754 single; requester i uses bits `[32*i+31:32*i]`.
- `req_x2`  in  `32*N_REQ`  operand 2, same packing.
- `req_sub`  in  `N_REQ`  per-requester subtract select (see Configuration).
- `rsp_valid`  out  1  response valid.
- `rsp_ready`  in  1  response consumer accept.
- `rsp_id`  out  `IDW`  index of the requester owning the response.
- `rsp_y`  out  32  sum.
- `rsp_ovf`  out  1  high when `rsp_y[30:23]==8'hFF`.
- `busy`  out  1  high when stage A or stage B holds a valid operation.

## Operation
**Stage A (issue register).**
- Contents: `a_vld`, `a_id`, `a_x1`, `a_x2`. `a_x2` is already sign-adjusted for subtract.
- `a_x1`/`a_x2` drive the `fadd` instance directly.

**Stage B (response register).**
- Contents: `b_vld`, `b_id`, `b_y`, `b_ovf`.
- Drives the `rsp_*` outputs directly, with no combinational path from the inputs.

**Flow control.**
- `b_adv = !b_vld | rsp_ready`.
- `a_adv = !a_vld | b_adv`.
- When `b_adv`: B loads A, i.e. `b_vld <= a_vld`, `b_y <= fadd y`.
- When `a_adv`: A loads the granted request, or clears `a_vld` if no request is valid.

**Arbitration.**
- Combinational round-robin over `req_valid` starting at pointer `rr` (`IDW` bits).
- The grant must not depend on `req_ready` or `rsp_ready`.
- `req_ready[i] = grant[i] & a_adv`.
- Acceptance is `req_valid[i] & req_ready[i]` at a rising edge. On acceptance, `rr <= (i+1) mod N_REQ`; otherwise `rr` holds.

**Requester rules.**
- A requester holds `req_valid` and its operands stable until accepted.
- The block never drops an accepted request.

**Output reset values.** `req_ready=0`, `rsp_valid=0`, `rsp_id=0`, `rsp_y=0`, `rsp_ovf=0`, `busy=0`. Internal state resets as `rr=0`, `a_vld=0`, `b_vld=0`, and all data registers to 0.

## Timing
- **Latency.** A request accepted at edge k appears on `rsp_*` with `rsp_valid=1` after edge k+1. Total latency is 2 edges to the response register.
- **Throughput.** One operation per cycle while `rsp_ready=1`.
- **Backpressure.**
  - `rsp_valid` and `rsp_*` stay stable while `rsp_ready=0`.
  - With B full and stalled, A holds.
  - With both stages full and stalled, all `req_ready` are 0.
  - Capacity is 2 in-flight operations.
- **Simultaneous drain and fill.** With B full, `rsp_ready=1` and A full, B takes A and A takes a new request in the same edge, with no bubble.
- **Reset mid-operation.** Asserting `rstn` low clears `a_vld`, `b_vld` and `rr` immediately, without waiting for a clock edge. In-flight operations are discarded with no response. The first acceptance after reset is granted from index 0 upward.
- **Wrap-around.** `rr` wraps from `N_REQ-1` to 0. This also applies for `N_REQ` values that are not a power of two.

## Configuration
- **`FADD_SUB_EN` defined.** On acceptance with `req_sub[i]=1`, stage A stores `{~x2[31], x2[30:0]}`, so the result is x1−x2.
- **`FADD_SUB_EN` undefined.** `req_sub` is ignored and the `req_sub` port remains. `a_x2` is stored unmodified, so the block only adds.

## Test plan
- Requester 0, x1=0x3F800000, x2=0x40000000, `rsp_ready=1` -> after 2 edges `rsp_valid=1`, `rsp_id=0`, `rsp_y=0x40400000`, `rsp_ovf=0`; `busy` falls one cycle after the response handshake.
- All 4 `req_valid` high and held, `rsp_ready=1`, from reset -> accepts in ID order 0,1,2,3,0, one per cycle; responses carry `rsp_id` in the same order with no gaps.
- Same as the previous scenario but `rsp_ready=0` for 5 cycles -> exactly 2 acceptances (IDs 0,1), then `req_ready=0`. `rsp_id=0` and `rsp_y` are held. On release, responses 0,1 are delivered in order, followed by ID 2.
- x1=0x40400000, x2=0x3F800000, `req_sub=1` -> with `FADD_SUB_EN`: `rsp_y=0x40000000`; without it: `rsp_y=0x40800000`.
- x1=x2=0x7F7FFFFF -> `rsp_y[30:23]=0xFF`, `rsp_ovf=1`.
- Two operations in flight, `rsp_ready=0`, pulse `rstn` low for 1 cycle -> `rsp_valid` and `busy` drop asynchronously, neither response is ever delivered, and the next grant goes to the lowest valid ID.

Source files
------------

// File: rtl/fadd_arbiter.sv
// Round-robin arbiter sharing one combinational single-precision adder among N_REQ requesters.
// Define FADD_SUB_EN to honour req_sub (x1 - x2); otherwise req_sub is ignored and the block only adds.

module fadd (
    input  logic [31:0] x1,
    input  logic [31:0] x2,
    output logic [31:0] y
);
    logic [31:0] big, sml;
    logic [7:0]  eb, es, d;
    logic [26:0] mb, ms, ms_sh, nrm;
    logic [27:0] sum;
    logic [4:0]  pos, lz;
    logic [9:0]  e;
    logic [24:0] rnd;
    logic        up, uflow;
    logic        unused_hid;

    // Denormal inputs and results flush to zero; rounding is nearest-even on guard/round/sticky.
    always_comb begin
        big = x1;
        sml = x2;
        if (x2[30:0] > x1[30:0]) begin
            big = x2;
            sml = x1;
        end
        eb = big[30:23];
        es = sml[30:23];
        mb = (eb == 8'd0) ? 27'd0 : {1'b1, big[22:0], 3'b000};
        ms = (es == 8'd0) ? 27'd0 : {1'b1, sml[22:0], 3'b000};
        d  = eb - es;
        if (d > 8'd26)
            ms_sh = {26'd0, |ms};
        else
            ms_sh = (ms >> d) | {26'd0, |(ms & ((27'd1 << d) - 27'd1))};
        if (big[31] == sml[31])
            sum = {1'b0, mb} + {1'b0, ms_sh};
        else
            sum = {1'b0, mb} - {1'b0, ms_sh};
        pos = 5'd0;
        for (int i = 0; i < 27; i++)
            if (sum[i]) pos = 5'(i);
        lz    = 5'd26 - pos;
        e     = {2'b00, eb};
        uflow = 1'b0;
        if (sum[27]) begin
            nrm = {sum[27:2], sum[1] | sum[0]};
            e   = e + 10'd1;
        end else begin
            nrm   = sum[26:0] << lz;
            uflow = ({5'd0, lz} >= e);
            e     = e - {5'd0, lz};
        end
        up  = nrm[2] & (nrm[1] | nrm[0] | nrm[3]);
        rnd = {1'b0, nrm[26:3]} + {24'd0, up};
        if (rnd[24]) begin
            rnd = {1'b0, rnd[24:1]};
            e   = e + 10'd1;
        end
        if (eb == 8'hFF)
            y = (es == 8'hFF && big[31] != sml[31] && big[22:0] == 23'd0) ? 32'h7FC00000 : big;
        else if (sum == 28'd0 || uflow)
            y = 32'd0;
        else if (e >= 10'd255)
            y = {big[31], 8'hFF, 23'd0};
        else
            y = {big[31], e[7:0], rnd[22:0]};
    end

    assign unused_hid = rnd[23];
endmodule

module fadd_arbiter #(
    parameter int N_REQ = 4,
    parameter int IDW   = $clog2(N_REQ)
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic [N_REQ-1:0]     req_valid,
    output logic [N_REQ-1:0]     req_ready,
    input  logic [32*N_REQ-1:0]  req_x1,
    input  logic [32*N_REQ-1:0]  req_x2,
    input  logic [N_REQ-1:0]     req_sub,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [IDW-1:0]       rsp_id,
    output logic [31:0]          rsp_y,
    output logic                 rsp_ovf,
    output logic                 busy
);
    logic             a_vld, b_vld, a_adv, b_adv, b_ovf;
    logic [IDW-1:0]   a_id, b_id, rr, rr_nxt, gnt_id, hi_id, lo_id;
    logic [31:0]      a_x1, a_x2, b_y, sum_y, sel_x1, sel_x2, x2_adj;
    logic             gnt_any, hi_any, lo_any, sel_sub;
    logic [N_REQ-1:0] gnt;

    fadd u_fadd (.x1(a_x1), .x2(a_x2), .y(sum_y));

    assign b_adv = !b_vld | rsp_ready;
    assign a_adv = !a_vld | b_adv;

    // First valid index at or above rr wins; otherwise the lowest valid index wraps around.
    always_comb begin
        hi_any = 1'b0;
        hi_id  = '0;
        lo_any = 1'b0;
        lo_id  = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (req_valid[i] && !hi_any && i >= int'(rr)) begin
                hi_any = 1'b1;
                hi_id  = IDW'(i);
            end
            if (req_valid[i] && !lo_any) begin
                lo_any = 1'b1;
                lo_id  = IDW'(i);
            end
        end
        gnt_any = hi_any | lo_any;
        gnt_id  = hi_any ? hi_id : lo_id;
        rr_nxt  = (gnt_id == IDW'(N_REQ - 1)) ? '0 : gnt_id + IDW'(1);
        gnt     = '0;
        sel_x1  = '0;
        sel_x2  = '0;
        sel_sub = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            gnt[i] = gnt_any && (gnt_id == IDW'(i));
            if (gnt[i]) begin
                sel_x1  = req_x1[32*i +: 32];
                sel_x2  = req_x2[32*i +: 32];
                sel_sub = req_sub[i];
            end
        end
    end

`ifdef FADD_SUB_EN
    assign x2_adj = {sel_x2[31] ^ sel_sub, sel_x2[30:0]};
`else
    logic unused_sub;
    assign x2_adj     = sel_x2;
    assign unused_sub = sel_sub;
`endif

    assign req_ready = gnt & {N_REQ{a_adv & rstn}};

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rr    <= '0;
            a_vld <= 1'b0;
            a_id  <= '0;
            a_x1  <= '0;
            a_x2  <= '0;
            b_vld <= 1'b0;
            b_id  <= '0;
            b_y   <= '0;
            b_ovf <= 1'b0;
        end else begin
            // Stage B: response register, loads whatever stage A holds.
            if (b_adv) begin
                b_vld <= a_vld;
                b_id  <= a_id;
                b_y   <= sum_y;
                b_ovf <= (sum_y[30:23] == 8'hFF);
            end
            // Stage A: issue register feeding the adder.
            if (a_adv) begin
                a_vld <= gnt_any;
                if (gnt_any) begin
                    a_id <= gnt_id;
                    a_x1 <= sel_x1;
                    a_x2 <= x2_adj;
                    rr   <= rr_nxt;
                end
            end
        end
    end

    assign rsp_valid = b_vld;
    assign rsp_id    = b_id;
    assign rsp_y     = b_y;
    assign rsp_ovf   = b_ovf;
    assign busy      = a_vld | b_vld;
endmodule

// File: tb/tb_fadd_arbiter.sv
// Directed bench for fadd_arbiter (N_REQ=4): latency, round-robin order, backpressure,
// subtract select, overflow flag and asynchronous reset with in-flight operations.
module tb_fadd_arbiter;
    localparam int N   = 4;
    localparam int IDW = 2;

    logic           clk = 1'b0;
    logic           rstn;
    logic [N-1:0]   req_valid, req_ready, req_sub;
    logic [32*N-1:0] req_x1, req_x2;
    logic           rsp_valid, rsp_ready, rsp_ovf, busy;
    logic [IDW-1:0] rsp_id;
    logic [31:0]    rsp_y;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    fadd_arbiter #(.N_REQ(N)) dut (
        .clk(clk), .rstn(rstn),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_x1(req_x1), .req_x2(req_x2), .req_sub(req_sub),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_id(rsp_id), .rsp_y(rsp_y), .rsp_ovf(rsp_ovf), .busy(busy)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    task automatic set_op(input int i, input logic [31:0] a, input logic [31:0] b, input logic s);
        req_x1[32*i +: 32] = a;
        req_x2[32*i +: 32] = b;
        req_sub[i]         = s;
    endtask

    task automatic std_ops();
        set_op(0, 32'h3F800000, 32'h3F800000, 1'b0);
        set_op(1, 32'h3F800000, 32'h40000000, 1'b0);
        set_op(2, 32'h3F800000, 32'h40400000, 1'b0);
        set_op(3, 32'h3F800000, 32'h40800000, 1'b0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rstn      = 1'b0;
        req_valid = '0;
        rsp_ready = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
    endtask

    logic [31:0] ytab [4]  = '{32'h40000000, 32'h40400000, 32'h40800000, 32'h40A00000};
    logic [3:0]  rdy3 [8]  = '{4'b0001, 4'b0010, 4'b0000, 4'b0000, 4'b0000, 4'b0100, 4'b1000, 4'b0001};
    int          id3  [8]  = '{-1, -1, 0, 0, 0, 0, 1, 2};
    logic [31:0] sub_exp;

    initial begin
        rstn = 1'b0; req_valid = '0; req_sub = '0; req_x1 = '0; req_x2 = '0; rsp_ready = 1'b0;
`ifdef FADD_SUB_EN
        sub_exp = 32'h40000000;
`else
        sub_exp = 32'h40800000;
`endif
        // Reset values, including req_ready held low while requests are pending.
        #1 req_valid = 4'hF;
        #1;
        chk("rst_req_ready", {28'd0, req_ready}, 32'd0);
        chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("rst_rsp_id", {30'd0, rsp_id}, 32'd0);
        chk("rst_rsp_y", rsp_y, 32'd0);
        chk("rst_rsp_ovf", {31'd0, rsp_ovf}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        req_valid = '0;
        @(negedge clk);
        rstn = 1'b1;

        // Single add 1.0 + 2.0 from requester 0.
        set_op(0, 32'h3F800000, 32'h40000000, 1'b0);
        req_valid = 4'b0001; rsp_ready = 1'b1;
        #1 chk("t1_req_ready", {28'd0, req_ready}, 32'd1);
        @(negedge clk);
        req_valid = '0;
        chk("t1_lat1_valid", {31'd0, rsp_valid}, 32'd0);
        chk("t1_lat1_busy", {31'd0, busy}, 32'd1);
        @(negedge clk);
        chk("t1_valid", {31'd0, rsp_valid}, 32'd1);
        chk("t1_id", {30'd0, rsp_id}, 32'd0);
        chk("t1_y", rsp_y, 32'h40400000);
        chk("t1_ovf", {31'd0, rsp_ovf}, 32'd0);
        chk("t1_busy", {31'd0, busy}, 32'd1);
        @(negedge clk);
        chk("t1_drain_valid", {31'd0, rsp_valid}, 32'd0);
        chk("t1_drain_busy", {31'd0, busy}, 32'd0);

        // All requesters held, consumer always ready: 0,1,2,3,0 back to back.
        do_reset();
        std_ops();
        req_valid = 4'hF; rsp_ready = 1'b1;
        for (int c = 0; c < 7; c++) begin
            #1;
            if (c < 5) chk($sformatf("rr_ready_c%0d", c), {28'd0, req_ready}, 32'd1 << (c % 4));
            chk($sformatf("rr_valid_c%0d", c), {31'd0, rsp_valid}, (c >= 2) ? 32'd1 : 32'd0);
            if (c >= 2) begin
                chk($sformatf("rr_id_c%0d", c), {30'd0, rsp_id}, 32'((c - 2) % 4));
                chk($sformatf("rr_y_c%0d", c), rsp_y, ytab[(c - 2) % 4]);
            end
            @(negedge clk);
        end

        // Consumer stalled for 5 cycles: two accepts, then hold, then in-order drain.
        do_reset();
        req_valid = 4'hF; rsp_ready = 1'b0;
        for (int c = 0; c < 8; c++) begin
            if (c == 5) rsp_ready = 1'b1;
            #1;
            chk($sformatf("bp_ready_c%0d", c), {28'd0, req_ready}, {28'd0, rdy3[c]});
            chk($sformatf("bp_valid_c%0d", c), {31'd0, rsp_valid}, (id3[c] >= 0) ? 32'd1 : 32'd0);
            if (id3[c] >= 0) begin
                chk($sformatf("bp_id_c%0d", c), {30'd0, rsp_id}, 32'(id3[c]));
                chk($sformatf("bp_y_c%0d", c), rsp_y, ytab[id3[c]]);
            end
            @(negedge clk);
        end

        // Subtract select: 3.0 - 1.0 when enabled, 3.0 + 1.0 otherwise.
        do_reset();
        set_op(2, 32'h40400000, 32'h3F800000, 1'b1);
        req_valid = 4'b0100; rsp_ready = 1'b1;
        #1 chk("sub_req_ready", {28'd0, req_ready}, 32'd4);
        @(negedge clk);
        req_valid = '0; req_sub = '0;
        @(negedge clk);
        chk("sub_valid", {31'd0, rsp_valid}, 32'd1);
        chk("sub_id", {30'd0, rsp_id}, 32'd2);
        chk("sub_y", rsp_y, sub_exp);

        // Largest finite + largest finite overflows to infinity.
        set_op(3, 32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0);
        req_valid = 4'b1000;
        #1 chk("ovf_req_ready", {28'd0, req_ready}, 32'd8);
        @(negedge clk);
        req_valid = '0;
        @(negedge clk);
        chk("ovf_id", {30'd0, rsp_id}, 32'd3);
        chk("ovf_y", rsp_y, 32'h7F800000);
        chk("ovf_flag", {31'd0, rsp_ovf}, 32'd1);

        // Reset with both stages full and stalled.
        do_reset();
        std_ops();
        req_valid = 4'hF; rsp_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #1;
        chk("ar_pre_busy", {31'd0, busy}, 32'd1);
        chk("ar_pre_valid", {31'd0, rsp_valid}, 32'd1);
        rstn = 1'b0;
        #1;
        chk("ar_async_valid", {31'd0, rsp_valid}, 32'd0);
        chk("ar_async_busy", {31'd0, busy}, 32'd0);
        chk("ar_async_ready", {28'd0, req_ready}, 32'd0);
        @(negedge clk);
        rstn = 1'b1; req_valid = 4'b1100; rsp_ready = 1'b1;
        #1 chk("ar_first_grant", {28'd0, req_ready}, 32'd4);
        @(negedge clk);
        chk("ar_c1_valid", {31'd0, rsp_valid}, 32'd0);
        chk("ar_c1_ready", {28'd0, req_ready}, 32'd8);
        @(negedge clk);
        chk("ar_c2_valid", {31'd0, rsp_valid}, 32'd1);
        chk("ar_c2_id", {30'd0, rsp_id}, 32'd2);
        @(negedge clk);
        req_valid = '0;
        chk("ar_c3_id", {30'd0, rsp_id}, 32'd3);
        chk("ar_c3_y", rsp_y, ytab[3]);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
